// File: rtl/mdio_responder.sv
// mdio_responder: PHY-side Clause 22 MDIO slave serving a 32 x 16 register file.
// MDC/MDIO are oversampled in the clk_int domain. Every protocol action is taken
// in the clk_int cycle in which a synchronized MDC rising edge is seen.
// Ports:
//   clk_int, rst_int        - only clock; asynchronous active-high reset
//   mdc_i, mdio_i           - asynchronous MDC / MDIO line input from the initiator
//   mdio_o, mdio_oe         - MDIO drive value and output enable (read data)
//   stat_i[15:0]            - live status value returned for reg 1
//   wr_stb, wr_addr, wr_data- one-cycle pulse plus address/data of an accepted write
//   frame_err               - one-cycle pulse on protocol error or MDC timeout
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int          PRE_LEN  = 32,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0DD1,
    parameter int          TIMEOUT  = 4096
) (
    input  logic        clk_int,
    input  logic        rst_int,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [15:0] stat_i,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);
    localparam int PW = $clog2(PRE_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA} state_t;

    state_t        state_q, state_d;
    logic          mdc_s1_q, mdc_s2_q, mdc_prev_q;
    logic          mdio_s1_q, mdio_s2_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    op_q, op_d;
    logic [4:0]    phy_q, phy_d;
    logic [4:0]    reg_q, reg_d;
    logic [15:0]   shift_q, shift_d;
    logic          oe_q, oe_d, o_q, o_d;
    logic          wr_stb_q, wr_stb_d, err_q, err_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic [15:0]   rf_q [32];
    logic          rf_we_s;
    logic          edge_s, is_rd_s, is_wr_s, match_s;
    logic [4:0]    rd_addr_s;
    logic [15:0]   rd_data_s;

    assign edge_s    = mdc_s2_q & ~mdc_prev_q;
    assign is_rd_s   = (op_q == 2'b10);
    assign is_wr_s   = (op_q == 2'b01);
    assign match_s   = (phy_q == PHY_ADDR);
    // Address formed by the final REGAD bit being sampled this edge.
    assign rd_addr_s = {reg_q[3:0], mdio_s2_q};

    assign mdio_o    = o_q;
    assign mdio_oe   = oe_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = err_q;

    // Read-data multiplexer: reg 0 bit 15 always reads 0, regs 1-3 are not from storage.
    always_comb begin
        rd_data_s = 16'h0000;
        case (rd_addr_s)
            5'd0:    rd_data_s = {1'b0, rf_q[0][14:0]};
            5'd1:    rd_data_s = stat_i;
            5'd2:    rd_data_s = PHY_ID1;
            5'd3:    rd_data_s = PHY_ID2;
            default: rd_data_s = rf_q[rd_addr_s];
        endcase
    end

    // Frame parser next-state and output logic, evaluated on MDC edge cycles.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pre_d     = pre_q;
        op_d      = op_q;
        phy_d     = phy_q;
        reg_d     = reg_q;
        shift_d   = shift_q;
        oe_d      = oe_q;
        o_d       = o_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        rf_we_s   = 1'b0;
        if (edge_s) begin
            tmo_d = {TW{1'b0}};
        end else if (tmo_q < TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end

        if (edge_s) begin
            case (state_q)
                S_IDLE: begin
                    if (mdio_s2_q) begin
                        pre_d = (pre_q < PRE_MAX) ? pre_q + PW'(1) : pre_q;
                    end else if (pre_q >= PRE_MAX) begin
                        state_d = S_ST;
                        pre_d   = {PW{1'b0}};
                    end else begin
                        pre_d = {PW{1'b0}};
                    end
                end
                S_ST: begin
                    if (mdio_s2_q) begin
                        state_d   = S_OP;
                        bit_cnt_d = 4'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_OP: begin
                    op_d = {op_q[0], mdio_s2_q};
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else if (({op_q[0], mdio_s2_q} == 2'b10) || ({op_q[0], mdio_s2_q} == 2'b01)) begin
                        state_d   = S_PHY;
                        bit_cnt_d = 4'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_PHY: begin
                    phy_d = {phy_q[3:0], mdio_s2_q};
                    if (bit_cnt_q == 4'd4) begin
                        state_d   = S_REG;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_REG: begin
                    reg_d = rd_addr_s;
                    if (bit_cnt_q == 4'd4) begin
                        state_d   = S_TA;
                        bit_cnt_d = 4'd0;
                        // Read data (including stat_i) is frozen here for the whole frame.
                        shift_d   = (is_rd_s && match_s) ? rd_data_s : 16'h0000;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        if (is_rd_s && match_s) begin
                            oe_d = 1'b1;
                            o_d  = 1'b0;
                        end else begin
                            oe_d = oe_q;
                        end
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 4'd0;
                        if (is_rd_s && match_s) begin
                            o_d     = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                        end else begin
                            o_d = o_q;
                        end
                    end
                end
                S_DATA: begin
                    if (is_rd_s && match_s) begin
                        if (bit_cnt_q == 4'd15) begin
                            oe_d = 1'b0;
                            o_d  = 1'b0;
                        end else begin
                            o_d     = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end else if (is_wr_s) begin
                        shift_d = {shift_q[14:0], mdio_s2_q};
                    end else begin
                        shift_d = shift_q;
                    end
                    if (bit_cnt_q == 4'd15) begin
                        state_d = S_IDLE;
                        pre_d   = {PW{1'b0}};
                        if (is_wr_s && match_s) begin
                            rf_we_s   = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = reg_q;
                            wr_data_d = {shift_q[14:0], mdio_s2_q};
                        end else begin
                            rf_we_s = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if ((state_q != S_IDLE) && (tmo_q == TMO_MAX)) begin
            // MDC stalled mid-frame: release the line and abandon the frame.
            oe_d    = 1'b0;
            o_d     = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
            pre_d   = {PW{1'b0}};
        end else begin
            state_d = state_q;
        end
    end

    // Synchronizers, edge history and frame state registers.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            mdc_s1_q   <= 1'b0;
            mdc_s2_q   <= 1'b0;
            mdc_prev_q <= 1'b0;
            mdio_s1_q  <= 1'b0;
            mdio_s2_q  <= 1'b0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            pre_q      <= {PW{1'b0}};
            tmo_q      <= {TW{1'b0}};
            op_q       <= 2'b00;
            phy_q      <= 5'd0;
            reg_q      <= 5'd0;
            shift_q    <= 16'h0000;
            oe_q       <= 1'b0;
            o_q        <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 16'h0000;
            err_q      <= 1'b0;
        end else begin
            mdc_s1_q   <= mdc_i;
            mdc_s2_q   <= mdc_s1_q;
            mdc_prev_q <= mdc_s2_q;
            mdio_s1_q  <= mdio_i;
            mdio_s2_q  <= mdio_s1_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pre_q      <= pre_d;
            tmo_q      <= tmo_d;
            op_q       <= op_d;
            phy_q      <= phy_d;
            reg_q      <= reg_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            o_q        <= o_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    // Register file: reg 0 never stores bit 15, regs 1-3 are not writable.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (rf_we_s) begin
            case (wr_addr_d)
                5'd0:                rf_q[0] <= {1'b0, wr_data_d[14:0]};
                5'd1, 5'd2, 5'd3:    rf_q[0] <= rf_q[0];
                default:             rf_q[wr_addr_d] <= wr_data_d;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_responder.sv
module tb_mdio_responder;
    localparam int TIMEOUT = 4096;

    logic        clk_int = 1'b0;
    logic        rst_int, mdc_i, mdio_i;
    logic        mdio_o, mdio_oe;
    logic [15:0] stat_i;
    logic        wr_stb, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          err_cnt  = 0;
    logic        oe_any;
    logic [15:0] exp_q [$];

    mdio_responder #(.TIMEOUT(TIMEOUT)) dut (
        .clk_int(clk_int), .rst_int(rst_int), .mdc_i(mdc_i), .mdio_i(mdio_i),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .stat_i(stat_i), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk_int = ~clk_int;

    always @(negedge clk_int) begin
        if (wr_stb) wr_cnt++;
        if (frame_err) err_cnt++;
        if (mdio_oe) oe_any = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One MDC period; DUT output is captured just before the rising edge.
    task automatic send_bit(input logic b, output logic o, output logic oe);
        mdio_i = b;
        mdc_i  = 1'b0;
        repeat (4) @(negedge clk_int);
        o  = mdio_o;
        oe = mdio_oe;
        mdc_i = 1'b1;
        repeat (4) @(negedge clk_int);
    endtask

    task automatic send_hdr(input int npre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rad);
        logic [13:0] hdr;
        logic o, oe;
        for (int i = 0; i < npre; i++) send_bit(1'b1, o, oe);
        hdr = {2'b01, op, phy, rad};
        for (int i = 13; i >= 0; i--) send_bit(hdr[i], o, oe);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] rad,
                              output logic [15:0] d, output logic ta_o, output logic ta_oe);
        logic o, oe;
        send_hdr(32, 2'b10, phy, rad);
        send_bit(1'b1, o, oe);
        send_bit(1'b1, ta_o, ta_oe);
        for (int i = 15; i >= 0; i--) begin
            send_bit(1'b1, o, oe);
            d[i] = o;
        end
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] rad, input logic [15:0] data);
        logic o, oe;
        send_hdr(32, 2'b01, phy, rad);
        send_bit(1'b1, o, oe);
        send_bit(1'b0, o, oe);
        for (int i = 15; i >= 0; i--) send_bit(data[i], o, oe);
    endtask

    initial begin
        logic [15:0] d;
        logic ta_o, ta_oe, o, oe;
        int w0, e0;

        rst_int = 1'b1; mdc_i = 1'b0; mdio_i = 1'b1; stat_i = 16'h796D;
        repeat (5) @(negedge clk_int);
        check("rst_mdio_oe", 32'(mdio_oe), 32'h0);
        check("rst_mdio_o", 32'(mdio_o), 32'h0);
        check("rst_wr_stb", 32'(wr_stb), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst_int = 1'b0;
        repeat (5) @(negedge clk_int);

        // Reset contents of a RW register
        exp_q.push_back(16'h0000);
        read_frame(5'd1, 5'd4, d, ta_o, ta_oe);
        check("rd_reg4_reset", 32'(d), 32'(exp_q.pop_front()));
        check("idle_no_wr", 32'(wr_cnt), 32'h0);
        check("idle_no_err", 32'(err_cnt), 32'h0);

        // PHY ID read with turnaround checks
        oe_any = 1'b0;
        exp_q.push_back(16'h0141);
        read_frame(5'd1, 5'd2, d, ta_o, ta_oe);
        check("rd_id1_ta2_o", 32'(ta_o), 32'h0);
        check("rd_id1_ta2_oe", 32'(ta_oe), 32'h1);
        check("rd_id1_data", 32'(d), 32'(exp_q.pop_front()));
        check("rd_id1_oe_release", 32'(mdio_oe), 32'h0);

        // RW register write/readback
        w0 = wr_cnt;
        write_frame(5'd1, 5'd4, 16'hA5C3);
        check("wr4_pulses", 32'(wr_cnt - w0), 32'h1);
        check("wr4_addr", 32'(wr_addr), 32'h4);
        check("wr4_data", 32'(wr_data), 32'hA5C3);
        exp_q.push_back(16'hA5C3);
        read_frame(5'd1, 5'd4, d, ta_o, ta_oe);
        check("rd_reg4", 32'(d), 32'(exp_q.pop_front()));
        check("rd_no_wr", 32'(wr_cnt - w0), 32'h1);

        // BMCR bit 15 self-clears
        write_frame(5'd1, 5'd0, 16'h9140);
        check("wr0_data", 32'(wr_data), 32'h9140);
        exp_q.push_back(16'h1140);
        read_frame(5'd1, 5'd0, d, ta_o, ta_oe);
        check("rd_reg0", 32'(d), 32'(exp_q.pop_front()));

        // Live status register
        exp_q.push_back(16'h796D);
        read_frame(5'd1, 5'd1, d, ta_o, ta_oe);
        check("rd_reg1", 32'(d), 32'(exp_q.pop_front()));

        // Non-matching PHY address
        oe_any = 1'b0;
        read_frame(5'd3, 5'd2, d, ta_o, ta_oe);
        check("nomatch_rd_oe", 32'(oe_any), 32'h0);
        w0 = wr_cnt;
        write_frame(5'd3, 5'd4, 16'h1234);
        check("nomatch_wr_stb", 32'(wr_cnt - w0), 32'h0);
        exp_q.push_back(16'hA5C3);
        read_frame(5'd1, 5'd4, d, ta_o, ta_oe);
        check("nomatch_reg4", 32'(d), 32'(exp_q.pop_front()));

        // Write to read-only ID register still strobes but does not stick
        w0 = wr_cnt;
        write_frame(5'd1, 5'd2, 16'hFFFF);
        check("wr_ro_pulse", 32'(wr_cnt - w0), 32'h1);
        exp_q.push_back(16'h0141);
        read_frame(5'd1, 5'd2, d, ta_o, ta_oe);
        check("rd_ro_unchanged", 32'(d), 32'(exp_q.pop_front()));

        // Short preamble is ignored
        oe_any = 1'b0; e0 = err_cnt; w0 = wr_cnt;
        send_hdr(31, 2'b10, 5'd1, 5'd2);
        for (int i = 0; i < 18; i++) send_bit(1'b1, o, oe);
        check("short_pre_oe", 32'(oe_any), 32'h0);
        check("short_pre_err", 32'(err_cnt - e0), 32'h0);

        // Illegal opcode
        e0 = err_cnt;
        send_hdr(32, 2'b00, 5'd1, 5'd2);
        for (int i = 0; i < 18; i++) send_bit(1'b1, o, oe);
        check("bad_op_err", 32'(err_cnt - e0), 32'h1);
        check("bad_op_no_wr", 32'(wr_cnt - w0), 32'h0);

        // MDC stall mid-read
        send_hdr(32, 2'b10, 5'd1, 5'd2);
        send_bit(1'b1, o, oe);
        check("stall_oe_before", 32'(mdio_oe), 32'h1);
        e0 = err_cnt;
        repeat (TIMEOUT + 20) @(negedge clk_int);
        check("tmo_err", 32'(err_cnt - e0), 32'h1);
        check("tmo_oe", 32'(mdio_oe), 32'h0);
        exp_q.push_back(16'h0DD1);
        read_frame(5'd1, 5'd3, d, ta_o, ta_oe);
        check("tmo_recover_rd", 32'(d), 32'(exp_q.pop_front()));

        // Asynchronous reset mid-frame
        send_hdr(32, 2'b10, 5'd1, 5'd4);
        send_bit(1'b1, o, oe);
        check("arst_oe_before", 32'(mdio_oe), 32'h1);
        #2 rst_int = 1'b1;
        #1 check("arst_oe_async", 32'(mdio_oe), 32'h0);
        repeat (3) @(negedge clk_int);
        rst_int = 1'b0;
        check("arst_wr_data", 32'(wr_data), 32'h0);
        repeat (3) @(negedge clk_int);
        exp_q.push_back(16'h0000);
        read_frame(5'd1, 5'd4, d, ta_o, ta_oe);
        check("arst_reg4_cleared", 32'(d), 32'(exp_q.pop_front()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
